tlb_op_ctrl: RTL and testbench
==============================

Name: tlb_op_ctrl

Overview:
- Sequences the TLB-management instructions TLBSRCH, TLBRD, TLBWR, TLBFILL and INVTLB between the writeback stage, the CSR unit and the TLB array.
- Converts a single-cycle instruction request into multi-cycle TLB accesses, then issues the CSR update strobes (s1e/re).
- Stalls the pipeline while busy and ends every op with a fetch-again request, so the next instruction refetches at pc+4.

Parameters:
- TLBNUM, 16, number of TLB entries (power of two)
- TLBNUMSIZE, 4, log2(TLBNUM), index width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- op_valid  in  1  TLB instruction at writeback; ignored while flush=1
- op_type  in  3  0=SRCH 1=RD 2=WR 3=FILL 4=INV
- inv_op  in  5  INVTLB op field
- inv_asid  in  10  INVTLB rj[9:0]
- inv_vppn  in  19  INVTLB rk[31:13]
- flush  in  1  exception/ertn committing this cycle
- op_ready  out  1  high only in IDLE
- op_done  out  1  one-cycle completion pulse
- fetch_again  out  1  pulses with op_done
- ine_exc  out  1  one-cycle pulse for INVTLB with inv_op>6
- csr_idx  in  TLBNUMSIZE  TLBIDX.index
- csr_vppn  in  19  TLBEHI.vppn
- csr_asid  in  10  ASID.asid
- csr_tlbr  in  1  ESTAT.ecode==TLBR
- csr_ne  in  1  TLBIDX.ne
- s1e  out  1  CSR search-update strobe
- s1_index  out  TLBNUMSIZE  search hit index
- s1_ne  out  1  ~found
- re  out  1  CSR read-update strobe
- r_ne  out  1  ~entry.e
- tlb_s_vppn  out  19  TLB search vppn
- tlb_s_asid  out  10  TLB search asid
- tlb_s_found  in  1  search hit (combinational)
- tlb_s_index  in  TLBNUMSIZE  hit index
- tlb_r_index  out  TLBNUMSIZE  TLB read index (combinational read)
- tlb_r_e  in  1  entry exists
- tlb_r_g  in  1  entry global
- tlb_r_asid  in  10  entry asid
- tlb_r_vppn  in  19  entry vppn
- tlb_r_ps  in  6  entry page size
- tlb_we  out  1  write strobe
- tlb_w_index  out  TLBNUMSIZE  write index
- tlb_w_e  out  1  write e bit
- tlb_clr  out  1  clear e of entry tlb_r_index

Behaviour:
- Reset: state=IDLE, fill_cnt=0. All strobes (s1e, re, tlb_we, tlb_clr, op_done, fetch_again, ine_exc) are 0. op_ready=1.
- Reset mid-op: returns to IDLE the next cycle with no partial strobes.
- fill_cnt increments every cycle and wraps mod TLBNUM. It is sampled on acceptance of a FILL.
- Acceptance: op_valid & op_ready & ~flush. Operands are latched on acceptance.
- FSM states: IDLE, SRCH, RD, WR, INV, DONE.
- SRCH (1 cycle):
  - Drives tlb_s_vppn=csr_vppn and tlb_s_asid=csr_asid.
  - Registers the search result.
  - DONE pulses s1e, with s1_index=hit index and s1_ne=~found.
  - On a miss, s1_index holds csr_idx.
- RD (1 cycle):
  - tlb_r_index=csr_idx.
  - Registers r_ne=~tlb_r_e.
  - DONE pulses re.
- WR (1 cycle): pulses tlb_we.
  - tlb_w_index = csr_idx for WR, latched fill_cnt for FILL.
  - tlb_w_e = csr_tlbr ? 1 : ~csr_ne.
- INV: any accepted inv_op>6 pulses ine_exc in the acceptance cycle and stays in IDLE; no op_done.
- INV scan: otherwise scan_idx walks 0..TLBNUM-1, one entry per cycle, with tlb_r_index=scan_idx.
  - tlb_clr=1 when tlb_r_e & match.
  - Match by inv_op:
    - 0,1: all entries
    - 2: g=1
    - 3: g=0
    - 4: g=0 & asid eq
    - 5: g=0 & asid eq & va eq
    - 6: (g=1 | asid eq) & va eq
  - va eq compares vppn[18:9] when ps==21, and the full 19 bits otherwise.
  - Goes to DONE after index TLBNUM-1. INV latency = TLBNUM+1 cycles.
- DONE (1 cycle): op_done=fetch_again=1, plus the op-specific CSR strobe, then back to IDLE.
- Latency from acceptance to op_done: 2 cycles for SRCH/RD/WR/FILL.
- Only one strobe of s1e/re/tlb_we is asserted in any cycle.
- flush has no effect once an op is accepted.

Decomposition:
- cpuDefine package gains typedefs tlb_op_e (op_type encoding) and inv_op_e, plus constant INV_OP_MAX=6.
- One sub-module, tlb_inv_match: combinational match function of (inv_op, asid, vppn, entry g/asid/vppn/ps).

Test Plan:
- SRCH with csr_vppn=0x12345 matching entry 5 -> s1e pulse 2 cycles after accept with s1_index=5, s1_ne=0. With no match -> s1_ne=1.
- RD csr_idx=3, entry 3 e=0 -> re pulse with r_ne=1, op_done and fetch_again coincident, op_ready low for 2 cycles.
- WR csr_idx=7, csr_ne=1, csr_tlbr=1 -> tlb_we with w_index=7, w_e=1. FILL accepted when fill_cnt=15 -> w_index=15, counter wraps to 0.
- INVTLB op=5, asid=0x3, vppn=0x1000, entries {2: g0 asid3 ps12 match; 4: g1 same va; 9: ps21 vppn high match} -> tlb_clr only at scan 2 and 9, op_done at cycle 17.
- INVTLB op=7 -> ine_exc pulse, no op_done, op_ready stays 1. op_valid with flush=1 -> not accepted.
- Reset asserted during INV scan at index 6 -> next cycle IDLE, no tlb_clr, op_done never pulses.

Source files
------------

// File: rtl/tlb_op_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// tlb_op_ctrl_pkg
//   Shared types and constants for the TLB-management instruction sequencer.
//   - tlb_op_e    : op_type encoding delivered by the writeback stage
//   - inv_op_e    : INVTLB op field encoding (values above INV_OP_MAX are
//                   illegal and raise an instruction-not-exist exception)
//   - tlb_state_e : sequencer FSM states, also exported on the debug port
//   - vppn_match  : virtual-page compare honouring the entry page size
// -----------------------------------------------------------------------------
package tlb_op_ctrl_pkg;

    typedef enum logic [2:0] {
        TLB_OP_SRCH = 3'd0,
        TLB_OP_RD   = 3'd1,
        TLB_OP_WR   = 3'd2,
        TLB_OP_FILL = 3'd3,
        TLB_OP_INV  = 3'd4
    } tlb_op_e;

    typedef enum logic [4:0] {
        INV_ALL0      = 5'd0,
        INV_ALL1      = 5'd1,
        INV_G1        = 5'd2,
        INV_G0        = 5'd3,
        INV_G0_ASID   = 5'd4,
        INV_G0_ASID_VA = 5'd5,
        INV_GASID_VA  = 5'd6
    } inv_op_e;

    localparam logic [4:0] INV_OP_MAX = 5'd6;

    // Page size code of a 4 MB (huge) page: only vppn[18:9] is significant.
    localparam logic [5:0] PS_HUGE = 6'd21;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SRCH = 3'd1,
        ST_RD   = 3'd2,
        ST_WR   = 3'd3,
        ST_INV  = 3'd4,
        ST_DONE = 3'd5
    } tlb_state_e;

    // Huge pages ignore the low 9 vppn bits; normal pages compare all 19.
    function automatic logic vppn_match(input logic [18:0] a,
                                        input logic [18:0] b,
                                        input logic [5:0]  ps);
        if (ps == PS_HUGE) begin
            return (a[18:9] == b[18:9]);
        end
        return (a == b);
    endfunction

endpackage

// File: rtl/tlb_op_ctrl_inv.sv
// -----------------------------------------------------------------------------
// tlb_inv_match
//   Combinational INVTLB selection rule for one TLB entry.
//   Ports:
//     inv_op    in  5   INVTLB op field (0..6 legal)
//     inv_asid  in  10  asid operand (rj[9:0])
//     inv_vppn  in  19  va operand (rk[31:13])
//     ent_g     in  1   entry global bit
//     ent_asid  in  10  entry asid
//     ent_vppn  in  19  entry vppn
//     ent_ps    in  6   entry page size
//     match     out 1   entry is selected by this INVTLB op
//   The entry valid (e) bit is not considered here; the caller gates with it.
// -----------------------------------------------------------------------------
module tlb_inv_match
    import tlb_op_ctrl_pkg::*;
(
    input  logic [4:0]  inv_op,
    input  logic [9:0]  inv_asid,
    input  logic [18:0] inv_vppn,
    input  logic        ent_g,
    input  logic [9:0]  ent_asid,
    input  logic [18:0] ent_vppn,
    input  logic [5:0]  ent_ps,
    output logic        match
);

    logic asid_eq;
    logic va_eq;

    assign asid_eq = (inv_asid == ent_asid);
    assign va_eq   = vppn_match(inv_vppn, ent_vppn, ent_ps);

    always_comb begin
        match = 1'b0;
        case (inv_op)
            INV_ALL0,
            INV_ALL1:       match = 1'b1;
            INV_G1:         match = ent_g;
            INV_G0:         match = ~ent_g;
            INV_G0_ASID:    match = ~ent_g & asid_eq;
            INV_G0_ASID_VA: match = ~ent_g & asid_eq & va_eq;
            INV_GASID_VA:   match = (ent_g | asid_eq) & va_eq;
            default:        match = 1'b0;
        endcase
    end

endmodule

// File: rtl/tlb_op_ctrl.sv
// -----------------------------------------------------------------------------
// tlb_op_ctrl
//   Sequences TLBSRCH / TLBRD / TLBWR / TLBFILL / INVTLB between writeback,
//   the CSR unit and the TLB array. A single-cycle request becomes one or more
//   TLB access cycles, followed by a DONE cycle that raises op_done,
//   fetch_again and the op-specific CSR update strobe.
//
//   Request handshake: a request is taken in the cycle where
//   op_valid & op_ready & ~flush are all high; op_ready is high only in IDLE,
//   operands are captured in that cycle, and nothing on the request side is
//   looked at again (including flush) until the op has finished.
//
//   Ports:
//     clk, reset               clock, synchronous active-high reset
//     op_valid/op_type         request and its opcode (tlb_op_e)
//     inv_op/inv_asid/inv_vppn INVTLB operands
//     flush                    commit-time exception/ertn, blocks acceptance
//     op_ready                 idle, can accept
//     op_done, fetch_again     one-cycle completion pulses
//     ine_exc                  illegal INVTLB op, pulses in acceptance cycle
//     csr_idx/vppn/asid/tlbr/ne CSR state feeding the accesses
//     s1e, s1_index, s1_ne     search-result CSR update
//     re, r_ne                 read-result CSR update
//     tlb_s_* / tlb_r_* / tlb_w_* / tlb_we / tlb_clr  TLB array interface
//     dbg_state                current FSM state
// -----------------------------------------------------------------------------
module tlb_op_ctrl
    import tlb_op_ctrl_pkg::*;
#(
    parameter int TLBNUM     = 16,
    parameter int TLBNUMSIZE = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  op_valid,
    input  logic [2:0]            op_type,
    input  logic [4:0]            inv_op,
    input  logic [9:0]            inv_asid,
    input  logic [18:0]           inv_vppn,
    input  logic                  flush,
    output logic                  op_ready,
    output logic                  op_done,
    output logic                  fetch_again,
    output logic                  ine_exc,
    input  logic [TLBNUMSIZE-1:0] csr_idx,
    input  logic [18:0]           csr_vppn,
    input  logic [9:0]            csr_asid,
    input  logic                  csr_tlbr,
    input  logic                  csr_ne,
    output logic                  s1e,
    output logic [TLBNUMSIZE-1:0] s1_index,
    output logic                  s1_ne,
    output logic                  re,
    output logic                  r_ne,
    output logic [18:0]           tlb_s_vppn,
    output logic [9:0]            tlb_s_asid,
    input  logic                  tlb_s_found,
    input  logic [TLBNUMSIZE-1:0] tlb_s_index,
    output logic [TLBNUMSIZE-1:0] tlb_r_index,
    input  logic                  tlb_r_e,
    input  logic                  tlb_r_g,
    input  logic [9:0]            tlb_r_asid,
    input  logic [18:0]           tlb_r_vppn,
    input  logic [5:0]            tlb_r_ps,
    output logic                  tlb_we,
    output logic [TLBNUMSIZE-1:0] tlb_w_index,
    output logic                  tlb_w_e,
    output logic                  tlb_clr,
    output tlb_state_e            dbg_state
);

    localparam logic [TLBNUMSIZE-1:0] LAST_IDX = TLBNUMSIZE'(TLBNUM - 1);

    tlb_state_e            state_q;
    tlb_state_e            state_d;
    tlb_op_e               op_q;
    logic [4:0]            inv_op_q;
    logic [9:0]            inv_asid_q;
    logic [18:0]           inv_vppn_q;
    logic [TLBNUMSIZE-1:0] fill_cnt;
    logic [TLBNUMSIZE-1:0] fill_idx_q;
    logic [TLBNUMSIZE-1:0] scan_idx;
    logic [TLBNUMSIZE-1:0] s1_index_q;
    logic                  s1_ne_q;
    logic                  r_ne_q;
    logic                  accept;
    logic                  inv_illegal;
    logic                  inv_hit;
    logic                  live;

    // Strobes are suppressed while reset is high so an op cut short by reset
    // leaves no partial TLB or CSR update behind.
    assign live        = ~reset;
    assign accept      = op_valid & (state_q == ST_IDLE) & ~flush & live;
    assign inv_illegal = (op_type == TLB_OP_INV) & (inv_op > INV_OP_MAX);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    case (op_type)
                        TLB_OP_SRCH: state_d = ST_SRCH;
                        TLB_OP_RD:   state_d = ST_RD;
                        TLB_OP_WR,
                        TLB_OP_FILL: state_d = ST_WR;
                        TLB_OP_INV:  state_d = inv_illegal ? ST_IDLE : ST_INV;
                        default:     state_d = ST_IDLE;
                    endcase
                end
            end
            ST_SRCH,
            ST_RD,
            ST_WR:   state_d = ST_DONE;
            ST_INV: begin
                if (scan_idx == LAST_IDX) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State, operand capture, result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            op_q       <= TLB_OP_SRCH;
            inv_op_q   <= '0;
            inv_asid_q <= '0;
            inv_vppn_q <= '0;
            fill_cnt   <= '0;
            fill_idx_q <= '0;
            scan_idx   <= '0;
            s1_index_q <= '0;
            s1_ne_q    <= 1'b0;
            r_ne_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            // Free-running pseudo-random replacement pointer for TLBFILL.
            fill_cnt <= fill_cnt + 1'b1;

            if (accept) begin
                op_q       <= tlb_op_e'(op_type);
                inv_op_q   <= inv_op;
                inv_asid_q <= inv_asid;
                inv_vppn_q <= inv_vppn;
                fill_idx_q <= fill_cnt;
                scan_idx   <= '0;
            end else if (state_q == ST_INV) begin
                scan_idx <= scan_idx + 1'b1;
            end

            // A miss keeps TLBIDX.index unchanged, so feed csr_idx back.
            if (state_q == ST_SRCH) begin
                s1_ne_q    <= ~tlb_s_found;
                s1_index_q <= tlb_s_found ? tlb_s_index : csr_idx;
            end

            if (state_q == ST_RD) begin
                r_ne_q <= ~tlb_r_e;
            end
        end
    end

    // ------------------------------------------------------------------
    // INVTLB entry selection for the entry currently being scanned
    // ------------------------------------------------------------------
    tlb_inv_match u_inv_match (
        .inv_op   (inv_op_q),
        .inv_asid (inv_asid_q),
        .inv_vppn (inv_vppn_q),
        .ent_g    (tlb_r_g),
        .ent_asid (tlb_r_asid),
        .ent_vppn (tlb_r_vppn),
        .ent_ps   (tlb_r_ps),
        .match    (inv_hit)
    );

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign op_ready    = (state_q == ST_IDLE);
    assign op_done     = live & (state_q == ST_DONE);
    assign fetch_again = op_done;
    assign ine_exc     = accept & inv_illegal;

    assign s1e      = op_done & (op_q == TLB_OP_SRCH);
    assign s1_index = s1_index_q;
    assign s1_ne    = s1_ne_q;
    assign re       = op_done & (op_q == TLB_OP_RD);
    assign r_ne     = r_ne_q;

    assign tlb_s_vppn = csr_vppn;
    assign tlb_s_asid = csr_asid;

    // The read port serves TLBRD (csr_idx) and the INVTLB walk (scan_idx).
    assign tlb_r_index = (state_q == ST_INV) ? scan_idx : csr_idx;

    assign tlb_we      = live & (state_q == ST_WR);
    assign tlb_w_index = (op_q == TLB_OP_FILL) ? fill_idx_q : csr_idx;
    // A refill handler always writes a valid entry regardless of TLBIDX.ne.
    assign tlb_w_e     = csr_tlbr | ~csr_ne;

    assign tlb_clr = live & (state_q == ST_INV) & tlb_r_e & inv_hit;

    assign dbg_state = state_q;

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// -----------------------------------------------------------------------------
// tb_tlb_op_ctrl
//   Bench for tlb_op_ctrl: a static TLB array model answers search/read
//   ports, a transaction-level model predicts per-cycle strobes from the
//   accepted op and its cycle, and directed tests pin key values by hand.
// -----------------------------------------------------------------------------
module tb_tlb_op_ctrl;
  import tlb_op_ctrl_pkg::*;

  localparam int TLBNUM = 16;
  localparam int TLBNUMSIZE = 4;
  localparam int NEVER = 1 << 30;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic                  op_valid, flush;
  logic [2:0]            op_type;
  logic [4:0]            inv_op;
  logic [9:0]            inv_asid;
  logic [18:0]           inv_vppn;
  logic                  op_ready, op_done, fetch_again, ine_exc;
  logic [TLBNUMSIZE-1:0] csr_idx;
  logic [18:0]           csr_vppn;
  logic [9:0]            csr_asid;
  logic                  csr_tlbr, csr_ne;
  logic                  s1e, s1_ne, re, r_ne;
  logic [TLBNUMSIZE-1:0] s1_index;
  logic [18:0]           tlb_s_vppn;
  logic [9:0]            tlb_s_asid;
  logic                  tlb_s_found;
  logic [TLBNUMSIZE-1:0] tlb_s_index;
  logic [TLBNUMSIZE-1:0] tlb_r_index;
  logic                  tlb_r_e, tlb_r_g;
  logic [9:0]            tlb_r_asid;
  logic [18:0]           tlb_r_vppn;
  logic [5:0]            tlb_r_ps;
  logic                  tlb_we, tlb_w_e, tlb_clr;
  logic [TLBNUMSIZE-1:0] tlb_w_index;
  tlb_state_e            dbg_state;

  tlb_op_ctrl #(.TLBNUM(TLBNUM), .TLBNUMSIZE(TLBNUMSIZE)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_type(op_type),
    .inv_op(inv_op), .inv_asid(inv_asid), .inv_vppn(inv_vppn), .flush(flush),
    .op_ready(op_ready), .op_done(op_done), .fetch_again(fetch_again),
    .ine_exc(ine_exc), .csr_idx(csr_idx), .csr_vppn(csr_vppn),
    .csr_asid(csr_asid), .csr_tlbr(csr_tlbr), .csr_ne(csr_ne), .s1e(s1e),
    .s1_index(s1_index), .s1_ne(s1_ne), .re(re), .r_ne(r_ne),
    .tlb_s_vppn(tlb_s_vppn), .tlb_s_asid(tlb_s_asid),
    .tlb_s_found(tlb_s_found), .tlb_s_index(tlb_s_index),
    .tlb_r_index(tlb_r_index), .tlb_r_e(tlb_r_e), .tlb_r_g(tlb_r_g),
    .tlb_r_asid(tlb_r_asid), .tlb_r_vppn(tlb_r_vppn), .tlb_r_ps(tlb_r_ps),
    .tlb_we(tlb_we), .tlb_w_index(tlb_w_index), .tlb_w_e(tlb_w_e),
    .tlb_clr(tlb_clr), .dbg_state(dbg_state)
  );

  // ---------------- TLB array (static contents) ----------------
  bit          e_a    [TLBNUM];
  bit          g_a    [TLBNUM];
  logic [9:0]  asid_a [TLBNUM];
  logic [18:0] vppn_a [TLBNUM];
  logic [5:0]  ps_a   [TLBNUM];

  always_comb begin
    tlb_s_found = 1'b0;
    tlb_s_index = '0;
    for (int i = TLBNUM - 1; i >= 0; i--) begin
      if (e_a[i] && (g_a[i] || asid_a[i] == tlb_s_asid) &&
          ((ps_a[i] == 6'd21) ? (tlb_s_vppn[18:9] == vppn_a[i][18:9])
                              : (tlb_s_vppn == vppn_a[i]))) begin
        tlb_s_found = 1'b1;
        tlb_s_index = TLBNUMSIZE'(i);
      end
    end
  end

  assign tlb_r_e    = e_a[tlb_r_index];
  assign tlb_r_g    = g_a[tlb_r_index];
  assign tlb_r_asid = asid_a[tlb_r_index];
  assign tlb_r_vppn = vppn_a[tlb_r_index];
  assign tlb_r_ps   = ps_a[tlb_r_index];

  // ---------------- reference model ----------------
  int acc_cyc = -100;
  int m_op = 0;
  int m_iop = 0;
  logic [9:0]  m_asid = '0;
  logic [18:0] m_vppn = '0;
  int m_fill = 0;
  int abort_cyc = NEVER;
  int ine_cyc = -100;
  int last_rst = 0;

  function automatic bit va_same(logic [18:0] v, int i);
    if (ps_a[i] == 6'd21) return v[18:9] == vppn_a[i][18:9];
    return v == vppn_a[i];
  endfunction

  function automatic bit inv_hits(int op, logic [9:0] a, logic [18:0] v, int i);
    bit a_ok;
    bit v_ok;
    a_ok = (asid_a[i] == a);
    v_ok = va_same(v, i);
    case (op)
      0, 1: return 1'b1;
      2: return g_a[i];
      3: return !g_a[i];
      4: return !g_a[i] && a_ok;
      5: return !g_a[i] && a_ok && v_ok;
      6: return (g_a[i] || a_ok) && v_ok;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int m_search(logic [18:0] v, logic [9:0] a);
    for (int i = 0; i < TLBNUM; i++)
      if (e_a[i] && (g_a[i] || asid_a[i] == a) && va_same(v, i)) return i;
    return -1;
  endfunction

  function automatic int lat_of(int op);
    return (op == 4) ? TLBNUM + 1 : 2;
  endfunction

  function automatic bit m_busy(int c);
    int k;
    k = c - acc_cyc;
    return (k >= 1) && (k <= lat_of(m_op)) && (c <= abort_cyc);
  endfunction

  function automatic int fill_now();
    return (cyc - last_rst - 1) % TLBNUM;
  endfunction

  // ---------------- scoreboard counters / logs ----------------
  int n_chk = 0;
  int n_pass = 0;
  int done_cnt = 0;
  int last_done_lat = -1;
  int nr_cnt = 0;
  int ine_cnt = 0;
  int log_s1_index = -1, log_s1_ne = -1, log_r_ne = -1;
  int log_w_index = -1, log_w_e = -1;
  logic [TLBNUMSIZE-1:0] clr_q[$];

  task automatic chk(string name, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    int k;
    int hit;
    bit live;
    bit done_e;
    logic [7:0] exp_v;
    logic [7:0] act_v;
    if (cyc >= 1) begin
      k = cyc - acc_cyc;
      live = (k >= 1) && (k <= lat_of(m_op)) && (cyc < abort_cyc);
      done_e = live && (k == lat_of(m_op));
      exp_v = {!m_busy(cyc), done_e, done_e,
               done_e && m_op == 0, done_e && m_op == 1,
               live && k == 1 && (m_op == 2 || m_op == 3),
               live && m_op == 4 && k <= TLBNUM && e_a[k-1] && inv_hits(m_iop, m_asid, m_vppn, k - 1),
               cyc == ine_cyc};
      act_v = {op_ready, op_done, fetch_again, s1e, re, tlb_we, tlb_clr, ine_exc};
      chk("strobes{rdy,done,fa,s1e,re,we,clr,ine}", int'(act_v), int'(exp_v));
      if (exp_v[4]) begin
        hit = m_search(csr_vppn, csr_asid);
        chk("s1_index", int'(s1_index), (hit >= 0) ? hit : int'(csr_idx));
        chk("s1_ne", int'(s1_ne), int'(hit < 0));
      end
      if (exp_v[3]) chk("r_ne", int'(r_ne), int'(!e_a[csr_idx]));
      if (exp_v[2]) begin
        chk("w_index", int'(tlb_w_index), (m_op == 3) ? m_fill : int'(csr_idx));
        chk("w_e", int'(tlb_w_e), int'(csr_tlbr || !csr_ne));
      end
      if (live && m_op == 4 && k <= TLBNUM) chk("scan_index", int'(tlb_r_index), k - 1);
      // event logs for the hand-computed checks
      if (op_done) begin done_cnt++; last_done_lat = cyc - acc_cyc; end
      if (!op_ready) nr_cnt++;
      if (ine_exc) ine_cnt++;
      if (tlb_clr) clr_q.push_back(tlb_r_index);
      if (s1e) begin log_s1_index = int'(s1_index); log_s1_ne = int'(s1_ne); end
      if (re) log_r_ne = int'(r_ne);
      if (tlb_we) begin log_w_index = int'(tlb_w_index); log_w_e = int'(tlb_w_e); end
    end
  end

  // ---------------- driver tasks ----------------
  // All tasks start and end at #1 after a rising edge.
  task automatic do_reset(int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      reset = 1'b1;
      last_rst = cyc;
      if (abort_cyc > cyc) abort_cyc = cyc;
    end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic do_op(int t, int iop, int a, int v, bit fl);
    op_valid = 1'b1;
    op_type  = 3'(t);
    inv_op   = 5'(iop);
    inv_asid = 10'(a);
    inv_vppn = 19'(v);
    flush    = fl;
    if (!m_busy(cyc) && !fl) begin
      if (t == 4 && iop > 6) begin
        ine_cyc = cyc;
      end else if (t <= 4) begin
        acc_cyc = cyc;
        m_op = t;
        m_iop = iop;
        m_asid = 10'(a);
        m_vppn = 19'(v);
        m_fill = fill_now();
        abort_cyc = NEVER;
      end
    end
    @(posedge clk); #1;
    op_valid = 1'b0;
    flush = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (op_ready) begin ok = 1'b1; break; end
    end
    if (!ok) chk("idle_timeout", 0, 1);
  endtask

  task automatic wait_fill(int v);
    for (int i = 0; i < 2 * TLBNUM && fill_now() != v; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic idle_cycles(int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // ---------------- directed tests ----------------
  int dc;
  int first_clr, second_clr, max_clr;

  initial begin
    for (int i = 0; i < TLBNUM; i++) begin
      e_a[i] = 0; g_a[i] = 0; asid_a[i] = '0; vppn_a[i] = '0; ps_a[i] = 6'd12;
    end
    e_a[2] = 1; asid_a[2] = 10'h3;  vppn_a[2] = 19'h01000;
    e_a[4] = 1; g_a[4] = 1; asid_a[4] = 10'h7; vppn_a[4] = 19'h01000;
    e_a[5] = 1; asid_a[5] = 10'h55; vppn_a[5] = 19'h12345;
    e_a[9] = 1; asid_a[9] = 10'h3;  vppn_a[9] = 19'h01005; ps_a[9] = 6'd21;
    asid_a[10] = 10'h3; vppn_a[10] = 19'h01000;
    e_a[12] = 1; asid_a[12] = 10'h4; vppn_a[12] = 19'h01000;

    op_valid = 0; op_type = 0; inv_op = 0; inv_asid = 0; inv_vppn = 0; flush = 0;
    csr_idx = 0; csr_vppn = 0; csr_asid = 0; csr_tlbr = 0; csr_ne = 0;

    do_reset(2);
    chk("reset_ready", int'(op_ready), 1);
    chk("reset_strobes", int'({s1e, re, tlb_we, tlb_clr, op_done, fetch_again, ine_exc}), 0);

    // SRCH hit on entry 5
    csr_vppn = 19'h12345; csr_asid = 10'h55; csr_idx = 4'd1;
    do_op(0, 0, 0, 0, 0);
    wait_idle();
    chk("srch_hit_index", log_s1_index, 5);
    chk("srch_hit_ne", log_s1_ne, 0);
    chk("srch_latency", last_done_lat, 2);

    // SRCH miss keeps csr_idx
    csr_vppn = 19'h7abcd; csr_asid = 10'h1; csr_idx = 4'd11;
    do_op(0, 0, 0, 0, 0);
    wait_idle();
    chk("srch_miss_ne", log_s1_ne, 1);
    chk("srch_miss_index", log_s1_index, 11);

    // RD of empty entry 3
    csr_idx = 4'd3; nr_cnt = 0;
    do_op(1, 0, 0, 0, 0);
    wait_idle();
    chk("rd_r_ne", log_r_ne, 1);
    chk("rd_busy_cycles", nr_cnt, 2);
    chk("rd_latency", last_done_lat, 2);

    // WR in refill context, then with ne=1 outside refill
    csr_idx = 4'd7; csr_ne = 1; csr_tlbr = 1;
    do_op(2, 0, 0, 0, 0);
    wait_idle();
    chk("wr_w_index", log_w_index, 7);
    chk("wr_w_e_tlbr", log_w_e, 1);
    csr_tlbr = 0;
    do_op(2, 0, 0, 0, 0);
    wait_idle();
    chk("wr_w_e_ne", log_w_e, 0);

    // FILL at fill_cnt=15, then again 3 cycles later (wrapped to 2)
    csr_ne = 0;
    wait_fill(15);
    do_op(3, 0, 0, 0, 0);
    wait_idle();
    chk("fill_w_index", log_w_index, 15);
    chk("fill_w_e", log_w_e, 1);
    do_op(3, 0, 0, 0, 0);
    wait_idle();
    chk("fill_wrap_index", log_w_index, 2);

    // INVTLB op 5: clears entries 2 and 9 only
    clr_q.delete();
    do_op(4, 5, 10'h3, 19'h01000, 0);
    wait_idle();
    first_clr = (clr_q.size() > 0) ? int'(clr_q[0]) : -1;
    second_clr = (clr_q.size() > 1) ? int'(clr_q[1]) : -1;
    chk("inv5_clr_count", clr_q.size(), 2);
    chk("inv5_clr_first", first_clr, 2);
    chk("inv5_clr_second", second_clr, 9);
    chk("inv5_latency", last_done_lat, 17);

    // INVTLB op 6 with asid 7: only the global entry 4
    clr_q.delete();
    do_op(4, 6, 10'h7, 19'h01000, 0);
    wait_idle();
    first_clr = (clr_q.size() > 0) ? int'(clr_q[0]) : -1;
    chk("inv6_clr_count", clr_q.size(), 1);
    chk("inv6_clr_first", first_clr, 4);

    // INVTLB op 7: illegal
    ine_cnt = 0; nr_cnt = 0; dc = done_cnt;
    do_op(4, 7, 0, 0, 0);
    idle_cycles(4);
    chk("inv7_ine", ine_cnt, 1);
    chk("inv7_no_done", done_cnt, dc);
    chk("inv7_ready", nr_cnt, 0);

    // request under flush is ignored
    nr_cnt = 0; dc = done_cnt;
    do_op(1, 0, 0, 0, 1);
    idle_cycles(4);
    chk("flush_no_done", done_cnt, dc);
    chk("flush_ready", nr_cnt, 0);

    // reset in the middle of an INVTLB walk, at scan index 6
    clr_q.delete(); dc = done_cnt;
    do_op(4, 0, 0, 0, 0);
    idle_cycles(5);
    do_reset(1);
    chk("midreset_ready", int'(op_ready), 1);
    idle_cycles(20);
    max_clr = -1;
    foreach (clr_q[i]) if (int'(clr_q[i]) > max_clr) max_clr = int'(clr_q[i]);
    chk("midreset_clr_count", clr_q.size(), 3);
    chk("midreset_clr_max", max_clr, 5);
    chk("midreset_no_done", done_cnt, dc);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
